llfifo_pop: RTL and testbench

- Dequeue (reader) controller for the multi-queue linked-list FIFO; complements the push/enqueue side that shares the llfifo_pkg types.
- On a pop request for queue ID it reads that queue's state, follows the head pointer through the link/data RAM, and returns the data word.
- It writes the updated queue_t back and releases the freed pointer to the free list.
- It sits between the client pop port and the shared queue-state table and link/data RAMs.

---
 rtl/llfifo_pop.sv | 174 +++++++++++++++++
 tb/tb_llfifo_pop.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llfifo_pop.sv
// llfifo_pop: dequeue controller for the multi-queue linked-list FIFO.
// Define LLFIFO_POP_CHECK_EN to add the sticky chk_err integrity flag.
package llfifo_pkg;
  localparam int PTR_N = 255;
  localparam int PTR_W = $clog2(PTR_N);
  localparam int W = 32;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [W-1:0] word_t;
  typedef struct packed {
    logic valid;
    ptr_t head;
    ptr_t tail;
    ptr_t cnt;
  } queue_t;
endpackage

module llfifo_pop
  import llfifo_pkg::*;
#(
  parameter int ID_N = 4,
  localparam int IW = $clog2(ID_N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pop_vld,
  input  logic [IW-1:0] pop_id,
  output logic          pop_rdy,
  output logic          qs_rd_en,
  output logic [IW-1:0] qs_rd_id,
  input  queue_t        qs_rd_q,
  output logic          qs_wr_en,
  output logic [IW-1:0] qs_wr_id,
  output queue_t        qs_wr_q,
  output logic          lnk_rd_en,
  output ptr_t          lnk_rd_ptr,
  input  ptr_t          lnk_rd_next,
  input  word_t         lnk_rd_word,
  output logic          free_vld,
  output ptr_t          free_ptr,
  output logic          rsp_vld,
  output logic [IW-1:0] rsp_id,
  output word_t         rsp_word,
  output logic          rsp_err,
  input  logic          rsp_rdy,
  output logic          busy,
  output logic [IW-1:0] busy_id
`ifdef LLFIFO_POP_CHECK_EN
  ,
  output logic          chk_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    QRD,
    LRD,
    RSP
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] id_q;
  ptr_t          head_q;
  ptr_t          tail_q;
  ptr_t          cnt_q;
  word_t         word_q;
  logic          err_q;
  logic          acc;
  logic          hit;
  logic          last;

  assign pop_rdy  = rst_n && (state == IDLE);
  assign acc      = pop_vld && pop_rdy;
  assign qs_rd_en = acc;
  assign qs_rd_id = pop_id;
  assign hit      = qs_rd_q.valid && (qs_rd_q.cnt != '0);
  assign last     = (cnt_q == PTR_W'(1));

  assign qs_wr_id = id_q;
  assign rsp_id   = id_q;
  assign rsp_word = word_q;
  assign rsp_err  = err_q;
  assign busy     = (state != IDLE);
  assign busy_id  = id_q;

  always_comb begin
    state_nxt  = state;
    lnk_rd_en  = 1'b0;
    lnk_rd_ptr = '0;
    qs_wr_en   = 1'b0;
    qs_wr_q    = '0;
    free_vld   = 1'b0;
    free_ptr   = '0;
    rsp_vld    = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) state_nxt = QRD;
      end
      QRD: begin
        if (hit) begin
          lnk_rd_en  = 1'b1;
          lnk_rd_ptr = qs_rd_q.head;
          state_nxt  = LRD;
        end else begin
          state_nxt = RSP;
        end
      end
      LRD: begin
        qs_wr_en = 1'b1;
        free_vld = 1'b1;
        free_ptr = head_q;
        // cnt_q >= 2 here, so the decrement cannot wrap
        if (!last) begin
          qs_wr_q.valid = 1'b1;
          qs_wr_q.head  = lnk_rd_next;
          qs_wr_q.tail  = tail_q;
          qs_wr_q.cnt   = cnt_q - PTR_W'(1);
        end
        state_nxt = RSP;
      end
      RSP: begin
        rsp_vld = 1'b1;
        if (rsp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      id_q   <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) id_q <= pop_id;
      if (state == QRD) begin
        head_q <= qs_rd_q.head;
        tail_q <= qs_rd_q.tail;
        cnt_q  <= qs_rd_q.cnt;
        if (!hit) begin
          word_q <= '0;
          err_q  <= 1'b1;
        end
      end
      if (state == LRD) begin
        word_q <= lnk_rd_word;
        err_q  <= 1'b0;
      end
    end
  end

`ifdef LLFIFO_POP_CHECK_EN
  logic chk_hit;

  assign chk_hit =
    ((state == QRD) && qs_rd_q.valid && (qs_rd_q.cnt == '0)) ||
    ((state == LRD) && !last && (cnt_q != '0) && (lnk_rd_next == '0)) ||
    ((state == LRD) && last && (head_q != tail_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (chk_hit) begin
      chk_err <= 1'b1;
      $error("llfifo_pop: queue %0d state inconsistent", id_q);
    end
  end
`endif

endmodule

// File: tb/tb_llfifo_pop.sv
// tb_llfifo_pop: random pops against a queue-of-entries reference model.
// Scoreboard queues hold expected RAM reads, writes, frees and responses.
module tb_llfifo_pop;
  import llfifo_pkg::*;

  localparam int ID_N = 4;
  localparam int IW = $clog2(ID_N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pop_vld = 1'b0;
  logic [IW-1:0] pop_id = '0;
  logic          pop_rdy;
  logic          qs_rd_en;
  logic [IW-1:0] qs_rd_id;
  queue_t        qs_rd_q;
  logic          qs_wr_en;
  logic [IW-1:0] qs_wr_id;
  queue_t        qs_wr_q;
  logic          lnk_rd_en;
  ptr_t          lnk_rd_ptr;
  ptr_t          lnk_rd_next;
  word_t         lnk_rd_word;
  logic          free_vld;
  ptr_t          free_ptr;
  logic          rsp_vld;
  logic [IW-1:0] rsp_id;
  word_t         rsp_word;
  logic          rsp_err;
  logic          rsp_rdy = 1'b0;
  logic          busy;
  logic [IW-1:0] busy_id;
`ifdef LLFIFO_POP_CHECK_EN
  logic          chk_err;
`endif

  llfifo_pop #(.ID_N(ID_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .pop_vld(pop_vld), .pop_id(pop_id), .pop_rdy(pop_rdy),
    .qs_rd_en(qs_rd_en), .qs_rd_id(qs_rd_id), .qs_rd_q(qs_rd_q),
    .qs_wr_en(qs_wr_en), .qs_wr_id(qs_wr_id), .qs_wr_q(qs_wr_q),
    .lnk_rd_en(lnk_rd_en), .lnk_rd_ptr(lnk_rd_ptr),
    .lnk_rd_next(lnk_rd_next), .lnk_rd_word(lnk_rd_word),
    .free_vld(free_vld), .free_ptr(free_ptr),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_word(rsp_word),
    .rsp_err(rsp_err), .rsp_rdy(rsp_rdy),
    .busy(busy), .busy_id(busy_id)
`ifdef LLFIFO_POP_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  // Environment RAMs: queue-state table and link/data RAM
  queue_t qs_tab [ID_N];
  ptr_t   lnk_next [PTR_N+1];
  word_t  lnk_word [PTR_N+1];
  logic          tb_wr_en = 1'b0;
  logic [IW-1:0] tb_wr_id = '0;
  queue_t        tb_wr_q = '0;

  always @(posedge clk) begin
    if (qs_rd_en) qs_rd_q <= qs_tab[qs_rd_id];
    if (lnk_rd_en) begin
      lnk_rd_next <= lnk_next[lnk_rd_ptr];
      lnk_rd_word <= lnk_word[lnk_rd_ptr];
    end
    if (qs_wr_en) qs_tab[qs_wr_id] <= qs_wr_q;
    if (tb_wr_en) qs_tab[tb_wr_id] <= tb_wr_q;
  end

  // Reference model: each queue is a list of (pointer, word) entries
  typedef struct packed { ptr_t p; word_t w; } ent_t;
  ent_t mq [ID_N][$];
  bit   mval [ID_N];

  typedef struct { int id; word_t w; logic err; int cy; } rsp_e;
  typedef struct { ptr_t p; int cy; } ptr_e;
  typedef struct { int id; queue_t q; int cy; } wr_e;
  rsp_e exp_rsp[$];
  ptr_e exp_lnk[$];
  ptr_e exp_free[$];
  wr_e  exp_wr[$];
  bit   rsp_seen = 0;

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (lnk_rd_en) begin
        if (exp_lnk.size() == 0) chk("lnk_unexpected", lnk_rd_en, 0);
        else begin
          ptr_e e;
          e = exp_lnk.pop_front();
          chk("lnk_ptr", lnk_rd_ptr, e.p);
          chk("lnk_cycle", cyc, e.cy);
        end
      end
      if (qs_wr_en) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", qs_wr_en, 0);
        else begin
          wr_e e;
          e = exp_wr.pop_front();
          chk("wr_id", qs_wr_id, e.id);
          chk("wr_q", qs_wr_q, e.q);
          chk("wr_cycle", cyc, e.cy);
        end
      end
      if (free_vld) begin
        if (exp_free.size() == 0) chk("free_unexpected", free_vld, 0);
        else begin
          ptr_e e;
          e = exp_free.pop_front();
          chk("free_ptr", free_ptr, e.p);
          chk("free_cycle", cyc, e.cy);
        end
      end
      if (rsp_vld) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_vld, 0);
        else begin
          rsp_e r;
          r = exp_rsp[0];
          if (!rsp_seen) chk("rsp_cycle", cyc, r.cy);
          rsp_seen = 1;
          chk("rsp_id", rsp_id, r.id);
          chk("rsp_word", rsp_word, r.w);
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_busy", {busy, pop_rdy}, 2'b10);
          if (rsp_rdy) begin
            void'(exp_rsp.pop_front());
            rsp_seen = 0;
          end
        end
      end
    end
  end

  bit   rdy_mode = 0;
  logic rdy_force = 1'b1;
  always @(posedge clk) begin
    #1;
    rsp_rdy = rdy_mode ? (($urandom % 4) != 0) : rdy_force;
  end

  task automatic tb_qw(input int id, input queue_t q);
    @(posedge clk); #1;
    tb_wr_en = 1'b1;
    tb_wr_id = IW'(id);
    tb_wr_q  = q;
    @(posedge clk); #1;
    tb_wr_en = 1'b0;
  endtask

  task automatic load_q(input int id, input ptr_t ps[$]);
    queue_t q;
    ent_t e;
    mq[id].delete();
    mval[id] = 1;
    for (int i = 0; i < ps.size(); i++) begin
      e.p = ps[i];
      e.w = $urandom;
      lnk_word[e.p] = e.w;
      lnk_next[e.p] = '0;
      if (i > 0) lnk_next[ps[i-1]] = e.p;
      mq[id].push_back(e);
    end
    q = '0;
    if (ps.size() != 0) begin
      q.valid = 1'b1;
      q.head = ps[0];
      q.tail = ps[ps.size()-1];
      q.cnt = ptr_t'(ps.size());
    end
    tb_qw(id, q);
  endtask

  task automatic set_invalid(input int id);
    queue_t q;
    mq[id].delete();
    mval[id] = 0;
    q.valid = 1'b0;
    q.head = 8'd3;
    q.tail = 8'd3;
    q.cnt = 8'd2;
    tb_qw(id, q);
  endtask

  task automatic expect_pop(input int id, input int c);
    rsp_e r;
    ptr_e pe;
    wr_e we;
    ent_t e;
    r.id = id;
    if (!mval[id] || mq[id].size() == 0) begin
      r.w = '0; r.err = 1'b1; r.cy = c + 2;
    end else begin
      e = mq[id].pop_front();
      pe.p = e.p; pe.cy = c + 1; exp_lnk.push_back(pe);
      pe.cy = c + 2; exp_free.push_back(pe);
      we.id = id; we.cy = c + 2; we.q = '0;
      if (mq[id].size() != 0) begin
        we.q.valid = 1'b1;
        we.q.head = mq[id][0].p;
        we.q.tail = mq[id][mq[id].size()-1].p;
        we.q.cnt = ptr_t'(mq[id].size());
      end
      exp_wr.push_back(we);
      r.w = e.w; r.err = 1'b0; r.cy = c + 3;
    end
    exp_rsp.push_back(r);
  endtask

  task automatic do_pop(input int id);
    int n;
    @(posedge clk); #1;
    pop_vld = 1'b1;
    pop_id = IW'(id);
    n = 0;
    @(negedge clk);
    while (!pop_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!pop_rdy) chk("pop_rdy_timeout", pop_rdy, 1);
    else begin
      chk("qs_rd", {qs_rd_en, qs_rd_id}, {1'b1, IW'(id)});
      expect_pop(id, cyc);
    end
    @(posedge clk); #1;
    pop_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_rsp.size() != 0 || busy) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%0d pending=%0d required=0",
               busy, exp_rsp.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ptr_t ps[$];
    queue_t sv;
    ent_t e;
    int np;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {pop_rdy, qs_rd_en, qs_wr_en, lnk_rd_en,
        free_vld, rsp_vld}, 6'b0);
    chk("rst_rsp", {rsp_word, rsp_id, rsp_err, busy_id}, '0);
    chk("rst_free", {free_ptr, qs_wr_q}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle", {pop_rdy, busy, qs_wr_en, lnk_rd_en, free_vld,
        rsp_vld}, 6'b100000);
`ifdef LLFIFO_POP_CHECK_EN
    chk("chk_err_rst", chk_err, 0);
`endif
    for (int i = 0; i < ID_N; i++) set_invalid(i);

    // Directed: 3-entry queue, single-entry queue, invalid queue
    ps = '{8'd5, 8'd7, 8'd9};
    load_q(2, ps);
    e = mq[2].pop_front();
    e.w = 32'hDEADBEEF;
    lnk_word[5] = e.w;
    mq[2].push_front(e);
    ps = '{8'd4};
    load_q(1, ps);
    do_pop(2);
    wait_idle();
    do_pop(1);
    wait_idle();
    do_pop(3);
    wait_idle();

    // Response stall with rsp_rdy low
    ps = '{8'd20, 8'd21};
    load_q(0, ps);
    rdy_force = 1'b0;
    do_pop(0);
    begin
      int n;
      n = 0;
      while (!rsp_vld && n < 20) begin n++; @(negedge clk); end
      chk("stall_rsp_seen", rsp_vld, 1);
    end
    repeat (5) @(negedge clk);
    rdy_force = 1'b1;
    wait_idle();
    chk("stall_after", {pop_rdy, busy}, 2'b10);

    // Reset asserted while in LRD
    ps = '{8'd30, 8'd31, 8'd32};
    load_q(2, ps);
    sv = qs_tab[2];
    @(posedge clk); #1;
    pop_vld = 1'b1;
    pop_id = 2'd2;
    @(negedge clk);
    begin
      ptr_e pe;
      pe.p = 8'd30;
      pe.cy = cyc + 1;
      exp_lnk.push_back(pe);
    end
    @(posedge clk); #1 pop_vld = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_lrd_strobes", {qs_wr_en, free_vld, rsp_vld}, 3'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_lrd_idle", {pop_rdy, busy}, 2'b10);
    chk("rst_lrd_qs", qs_tab[2], sv);
    chk("rst_lrd_lnk", exp_lnk.size(), 0);
    do_pop(2);
    wait_idle();

    // Random pops with random response backpressure
    rdy_mode = 1;
    for (int r = 0; r < 8; r++) begin
      wait_idle();
      np = 40;
      for (int id = 0; id < ID_N; id++) begin
        if ($urandom_range(0, 4) == 0) set_invalid(id);
        else begin
          int n;
          n = $urandom_range(0, 5);
          ps.delete();
          for (int k = 0; k < n; k++) begin
            ps.push_back(ptr_t'(np));
            np = np + $urandom_range(1, 3);
          end
          load_q(id, ps);
        end
      end
      for (int k = 0; k < 12; k++) do_pop($urandom_range(0, ID_N - 1));
    end
    wait_idle();
    rdy_mode = 0;
    chk("drain", {exp_lnk.size(), exp_wr.size(), exp_free.size()}, '0);

`ifdef LLFIFO_POP_CHECK_EN
    ps = '{8'd5, 8'd7, 8'd9};
    load_q(2, ps);
    lnk_next[5] = '0;
    e = mq[2][1];
    e.p = '0;
    mq[2][1] = e;
    chk("chk_err_clean", chk_err, 0);
    do_pop(2);
    wait_idle();
    chk("chk_err_set", chk_err, 1);
    repeat (3) @(negedge clk);
    chk("chk_err_sticky", chk_err, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("chk_err_clr", chk_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
